tipo_r_multiciclo: RTL and testbench
====================================

// Module: tipo_r_multiciclo
// PURPOSE
//  Clocked, parametrised successor of the single-cycle R-type datapath: executes one MIPS R-type
//  instruction at a time through a 4-state FSM (IDLE/READ/EXEC/WB) over an internal register bank.
//  Instructions arrive on a valid/ready handshake. Results leave on a one-cycle result strobe.
//  Adds funct decode, shifts, overflow/saturation and illegal-op detection. Sits between fetch and the memory stage.
// PARAMETERS
//  DATA_W   32  datapath and register width in bits (>=8)
//  NREG     32  implemented registers (2..32); addresses >= NREG read 0, writes dropped
//  SAT_EN   0   0: ADD/SUB wrap modulo 2^DATA_W; 1: signed saturation to max/min
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  in_valid     in   1       instruccion valid
//  in_ready     out  1       block can accept (1 only in IDLE)
//  instruccion  in   32      OP[31:26] Rs[25:21] Rt[20:16] Rd[15:11] Shamt[10:6] Fnc[5:0]
//  cfg_we       in   1       preload write strobe for the register bank
//  cfg_addr     in   5       preload register address
//  cfg_data     in   DATA_W  preload data
//  res_valid    out  1       one-cycle pulse: result/flags valid
//  resultado    out  DATA_W  ALU result (held until next res_valid)
//  res_rd       out  5       destination register of resultado
//  ovf          out  1       signed overflow on ADD/SUB (valid with res_valid)
//  err          out  1       illegal OP or Fnc (valid with res_valid)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, all registers=0, in_ready=0 while rst_n=0, then 1 in IDLE.
//   res_valid=0, resultado=0, res_rd=0, ovf=0, err=0. Reset mid-instruction aborts it; no writeback.
//  Handshake: accept when in_valid&in_ready at edge T; instruccion latched; IDLE->READ.
//   in_ready=0 in READ/EXEC/WB. in_valid while busy is ignored (source holds).
//  READ (T+1): op1=R[Rs], op2=R[Rt] latched. EXEC (T+2): ALU result and flags latched.
//  WB (T+3): R[Rd]<=result unless err or Rd==0 or Rd>=NREG; res_valid=1 for this one cycle; ->IDLE.
//   Back-to-back: next accept at earliest in the cycle after WB. Throughput 1 instr / 4 cycles.
//  Decode: OP must be 000000, else err=1. Fnc: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR,
//   100110 XOR, 100111 NOR, 101010 SLT (signed, result 1/0), 000000 SLL, 000010 SRL (op2 by Shamt).
//   Any other Fnc: err=1, resultado=0, ovf=0.
//  Shifts: amount=Shamt mod DATA_W; SRL zero-fills.
//  Overflow: ovf=1 iff signed overflow of ADD/SUB; SAT_EN=1 -> result clamps to 2^(W-1)-1 or -2^(W-1);
//   SAT_EN=0 -> wrapped sum kept. Other ops: ovf=0.
//  Register 0: always reads 0; writes (WB or cfg) ignored.
//  cfg_we: honoured only in IDLE (ignored otherwise, incl. reset). cfg_we with accept in same edge:
//   the write lands first; READ next cycle sees the new value.
//  resultado/res_rd/ovf/err hold their values between res_valid pulses.
// TESTING
//  1 preload R1=2023,R2=54; instr 0x00223820 (ADD $7,$1,$2) -> res_valid at T+3, resultado=2077, res_rd=7, R7=2077.
//  2 R1=0x7FFFFFFF,R2=1, ADD ->$3: SAT_EN=0 resultado=0x80000000,ovf=1; SAT_EN=1 resultado=0x7FFFFFFF,ovf=1.
//  3 R2=0x0000000F, SLL $4,$2,4 (Fnc 000000, Shamt 4) -> 0xF0; SLT R1=-1,R2=1 -> 1; SUB 5-7 -> 0xFFFFFFFE.
//  4 OP=000010 or Fnc=111111 -> err=1, no register change; ADD with Rd=0 -> R0 still reads 0.
//  5 in_valid held high for 3 instrs -> in_ready pulses every 4th cycle, three res_valid pulses, correct order.
//  6 rst_n low in EXEC -> no res_valid, Rd unchanged (regs cleared), in_ready=1 the cycle after release; cfg_we while busy ignored.

Source files
------------

// File: rtl/tipo_r_multiciclo.sv
// rtl/tipo_r_multiciclo.sv - multi-cycle MIPS R-type datapath with internal register bank
//
// Executes one R-type instruction at a time through IDLE -> READ -> EXEC -> WB.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready   instruction handshake; in_ready is high only in IDLE
//   instruccion[31:0]    OP[31:26] Rs[25:21] Rt[20:16] Rd[15:11] Shamt[10:6] Fnc[5:0]
//   cfg_we/addr/data     register bank preload, honoured only in IDLE
//   res_valid            one-cycle strobe qualifying resultado/res_rd/ovf/err
//   resultado, res_rd    ALU result and its destination register (held between strobes)
//   ovf, err             signed ADD/SUB overflow, illegal OP/Fnc
module tipo_r_multiciclo #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int SAT_EN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruccion,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              res_valid,
  output logic [DATA_W-1:0] resultado,
  output logic [4:0]        res_rd,
  output logic              ovf,
  output logic              err
);

  localparam int MSB = DATA_W - 1;
  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t              state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic [DATA_W-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [DATA_W-1:0]   alu_res_q, alu_res_d;
  logic                alu_ovf_q, alu_ovf_d, alu_err_q, alu_err_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   resultado_q, resultado_d;
  logic [4:0]          res_rd_q, res_rd_d;
  logic                ovf_q, ovf_d, err_q, err_d;
  // Register 0 is hard-wired to zero, so only 1..NREG-1 are stored.
  logic [DATA_W-1:0]   regs_q [1:NREG-1];
  logic [DATA_W-1:0]   regs_d [1:NREG-1];

  logic [5:0]          op_w, fn_w;
  logic [4:0]          rs_w, rt_w, rd_w, sh_w;
  logic [DATA_W-1:0]   rs_val, rt_val;
  logic [DATA_W-1:0]   sum_c, diff_c, alu_res_c;
  logic                add_ovf_c, sub_ovf_c, alu_ovf_c, alu_err_c;
  int                  shamt_eff;
  logic                accept;

  assign op_w = instr_q[31:26];
  assign rs_w = instr_q[25:21];
  assign rt_w = instr_q[20:16];
  assign rd_w = instr_q[15:11];
  assign sh_w = instr_q[10:6];
  assign fn_w = instr_q[5:0];

  // Gated by rst_n so the source sees not-ready for the whole reset window.
  assign in_ready = rst_n && (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;

  assign res_valid = res_valid_q;
  assign resultado = resultado_q;
  assign res_rd    = res_rd_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

  // Operand fetch: unimplemented addresses and register 0 read as zero.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    for (int i = 1; i < NREG; i++) begin
      if (int'(rs_w) == i) rs_val = regs_q[i];
      if (int'(rt_w) == i) rt_val = regs_q[i];
    end
  end

  always_comb begin
    sum_c     = op1_q + op2_q;
    diff_c    = op1_q - op2_q;
    add_ovf_c = (op1_q[MSB] == op2_q[MSB]) && (sum_c[MSB] != op1_q[MSB]);
    sub_ovf_c = (op1_q[MSB] != op2_q[MSB]) && (diff_c[MSB] != op1_q[MSB]);
    shamt_eff = int'(sh_w) % DATA_W;
    alu_res_c = '0;
    alu_ovf_c = 1'b0;
    alu_err_c = 1'b0;
    if (op_w != 6'b000000) begin
      alu_err_c = 1'b1;
    end else begin
      case (fn_w)
        F_ADD: begin
          alu_ovf_c = add_ovf_c;
          // On overflow both operands share op1's sign, so it picks the rail.
          alu_res_c = (add_ovf_c && SAT_EN != 0) ? (op1_q[MSB] ? MIN_V : MAX_V) : sum_c;
        end
        F_SUB: begin
          alu_ovf_c = sub_ovf_c;
          // Subtraction overflows toward the sign of the minuend.
          alu_res_c = (sub_ovf_c && SAT_EN != 0) ? (op1_q[MSB] ? MIN_V : MAX_V) : diff_c;
        end
        F_AND:   alu_res_c = op1_q & op2_q;
        F_OR:    alu_res_c = op1_q | op2_q;
        F_XOR:   alu_res_c = op1_q ^ op2_q;
        F_NOR:   alu_res_c = ~(op1_q | op2_q);
        F_SLT:   alu_res_c = DATA_W'($signed(op1_q) < $signed(op2_q));
        F_SLL:   alu_res_c = op2_q << shamt_eff;
        F_SRL:   alu_res_c = op2_q >> shamt_eff;
        default: alu_err_c = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    alu_res_d   = alu_res_q;
    alu_ovf_d   = alu_ovf_q;
    alu_err_d   = alu_err_q;
    res_valid_d = 1'b0;
    resultado_d = resultado_q;
    res_rd_d    = res_rd_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    regs_d      = regs_q;
    case (state_q)
      S_IDLE: begin
        // A preload on the accept edge lands before READ samples the bank.
        if (cfg_we) begin
          for (int i = 1; i < NREG; i++) begin
            if (int'(cfg_addr) == i) regs_d[i] = cfg_data;
          end
        end
        if (accept) begin
          instr_d = instruccion;
          state_d = S_READ;
        end
      end
      S_READ: begin
        op1_d   = rs_val;
        op2_d   = rt_val;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_res_d = alu_res_c;
        alu_ovf_d = alu_ovf_c;
        alu_err_d = alu_err_c;
        state_d   = S_WB;
      end
      S_WB: begin
        res_valid_d = 1'b1;
        resultado_d = alu_res_q;
        res_rd_d    = rd_w;
        ovf_d       = alu_ovf_q;
        err_d       = alu_err_q;
        if (!alu_err_q) begin
          for (int i = 1; i < NREG; i++) begin
            if (int'(rd_w) == i) regs_d[i] = alu_res_q;
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      alu_res_q   <= '0;
      alu_ovf_q   <= 1'b0;
      alu_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      resultado_q <= '0;
      res_rd_q    <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      alu_res_q   <= alu_res_d;
      alu_ovf_q   <= alu_ovf_d;
      alu_err_q   <= alu_err_d;
      res_valid_q <= res_valid_d;
      resultado_q <= resultado_d;
      res_rd_q    <= res_rd_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      regs_q      <= regs_d;
    end
  end

endmodule

// File: tb/tb_tipo_r_multiciclo.sv
// tb/tb_tipo_r_multiciclo.sv - self-checking bench for tipo_r_multiciclo
module tb_tipo_r_multiciclo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        cfg_we = 1'b0;
  logic [31:0] instruccion = '0;
  logic [31:0] cfg_data = '0;
  logic [4:0]  cfg_addr = '0;
  logic [1:0]  rdy, rv, ovf_o, err_o;
  logic [31:0] res [2];
  logic [4:0]  rrd [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] mreg [2][32];

  always #5 clk = ~clk;

  tipo_r_multiciclo #(.DATA_W(32), .NREG(32), .SAT_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .instruccion(instruccion), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .res_valid(rv[0]), .resultado(res[0]), .res_rd(rrd[0]), .ovf(ovf_o[0]), .err(err_o[0])
  );

  tipo_r_multiciclo #(.DATA_W(32), .NREG(16), .SAT_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .instruccion(instruccion), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .res_valid(rv[1]), .resultado(res[1]), .res_rd(rrd[1]), .ovf(ovf_o[1]), .err(err_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rs, input int rt,
                                      input int rd, input int sh, input int fn);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic int nreg_of(input int k);
    return (k == 1) ? 16 : 32;
  endfunction

  // Reference model: architectural register file plus the instruction's arithmetic meaning.
  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) mreg[k][i] = '0;
  endtask

  task automatic model_cfg(input logic [4:0] a, input logic [31:0] d);
    for (int k = 0; k < 2; k++)
      if (a != 0 && int'(a) < nreg_of(k)) mreg[k][a] = d;
  endtask

  function automatic logic [31:0] mread(input int k, input logic [4:0] a);
    if (a == 0 || int'(a) >= nreg_of(k)) return '0;
    return mreg[k][a];
  endfunction

  task automatic model_exec(input logic [31:0] ins, input int k,
                            output logic [31:0] r, output logic o, output logic e);
    logic [31:0] ua, ub;
    longint a, b, s;
    int sh;
    ua = mread(k, ins[25:21]);
    ub = mread(k, ins[20:16]);
    a  = longint'($signed(ua));
    b  = longint'($signed(ub));
    sh = int'(ins[10:6]) % 32;
    r = '0; o = 1'b0; e = 1'b0; s = 0;
    if (ins[31:26] != 6'd0) e = 1'b1;
    else begin
      case (ins[5:0])
        6'h20, 6'h22: begin
          s = (ins[5:0] == 6'h20) ? a + b : a - b;
          o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
          if (o && k == 1) r = (s > 0) ? 32'h7FFFFFFF : 32'h80000000;
          else r = s[31:0];
        end
        6'h24: r = ua & ub;
        6'h25: r = ua | ub;
        6'h26: r = ua ^ ub;
        6'h27: r = ~(ua | ub);
        6'h2A: r = (a < b) ? 32'd1 : 32'd0;
        6'h00: r = ub << sh;
        6'h02: r = ub >> sh;
        default: e = 1'b1;
      endcase
    end
    if (!e && ins[15:11] != 0 && int'(ins[15:11]) < nreg_of(k)) mreg[k][ins[15:11]] = r;
  endtask

  task automatic do_cfg(input int a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a[4:0]; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    model_cfg(a[4:0], d);
  endtask

  // Runs one instruction; optional preload on the accept edge (csame) or while busy (cbusy).
  task automatic issue(input logic [31:0] ins, input string tag, input bit csame,
                       input bit cbusy, input logic [4:0] ca, input logic [31:0] cd);
    logic [31:0] er [2];
    logic        eo [2];
    logic        ee [2];
    int          n;
    n = 0;
    while (rdy != 2'b11 && n < 20) begin @(negedge clk); n++; end
    chk({tag, " ready"}, 32'(rdy), 32'h3);
    if (csame) begin
      cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd;
      model_cfg(ca, cd);
    end
    instruccion = ins; in_valid = 1'b1;
    for (int k = 0; k < 2; k++) model_exec(ins, k, er[k], eo[k], ee[k]);
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    if (cbusy) begin cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd; end
    n = 1;
    while (rv != 2'b11 && n < 20) begin @(negedge clk); cfg_we = 1'b0; n++; end
    chk({tag, " latency"}, 32'(n), 32'd4);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s res d%0d", tag, k), res[k], er[k]);
      chk($sformatf("%s rd d%0d", tag, k), 32'(rrd[k]), 32'(ins[15:11]));
      chk($sformatf("%s ovf d%0d", tag, k), 32'(ovf_o[k]), 32'(eo[k]));
      chk($sformatf("%s err d%0d", tag, k), 32'(err_o[k]), 32'(ee[k]));
    end
    @(negedge clk);
    chk({tag, " pulse"}, 32'(rv), 32'h0);
  endtask

  task automatic rb(input int r, input string tag);
    issue(enc(0, r, 0, 0, 0, 6'h25), tag, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] ins;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        eo;
    logic        ee;
  } vec_t;

  vec_t vec [16];

  initial begin
    logic [31:0] ins_b [3];
    logic [31:0] qr0 [$];
    logic [31:0] qr1 [$];
    logic [31:0] tr;
    logic        to, te;
    int          idx, last_acc, naccept, nres, nrv;
    bit          pending;
    int          fns [9];

    vec[0]  = '{32'd2023, 32'd54, 32'h00223820, 32'd2077, 32'd2077, 1'b0, 1'b0};
    vec[1]  = '{32'h7FFFFFFF, 32'd1, enc(0, 1, 2, 3, 0, 6'h20), 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0};
    vec[2]  = '{32'd0, 32'hF, enc(0, 0, 2, 4, 4, 6'h00), 32'hF0, 32'hF0, 1'b0, 1'b0};
    vec[3]  = '{32'hFFFFFFFF, 32'd1, enc(0, 1, 2, 5, 0, 6'h2A), 32'd1, 32'd1, 1'b0, 1'b0};
    vec[4]  = '{32'd5, 32'd7, enc(0, 1, 2, 6, 0, 6'h22), 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1'b0};
    vec[5]  = '{32'h80000000, 32'd1, enc(0, 1, 2, 6, 0, 6'h22), 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0};
    vec[6]  = '{32'hF0F0, 32'hFF00, enc(0, 1, 2, 8, 0, 6'h24), 32'hF000, 32'hF000, 1'b0, 1'b0};
    vec[7]  = '{32'd0, 32'd0, enc(0, 1, 2, 8, 0, 6'h27), 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0};
    vec[8]  = '{32'd0, 32'h80000000, enc(0, 1, 2, 9, 31, 6'h02), 32'd1, 32'd1, 1'b0, 1'b0};
    vec[9]  = '{32'd3, 32'd4, enc(2, 1, 2, 9, 0, 6'h20), 32'd0, 32'd0, 1'b0, 1'b1};
    vec[10] = '{32'd3, 32'd4, enc(0, 1, 2, 9, 0, 6'h3F), 32'd0, 32'd0, 1'b0, 1'b1};
    vec[11] = '{32'hFF, 32'h0F, enc(0, 1, 2, 10, 0, 6'h26), 32'hF0, 32'hF0, 1'b0, 1'b0};
    vec[12] = '{32'h12, 32'h21, enc(0, 1, 2, 10, 0, 6'h25), 32'h33, 32'h33, 1'b0, 1'b0};
    vec[13] = '{32'd5, 32'hFFFFFFFD, enc(0, 1, 2, 11, 0, 6'h2A), 32'd0, 32'd0, 1'b0, 1'b0};
    vec[14] = '{32'd0, 32'd3, enc(0, 1, 2, 11, 31, 6'h00), 32'h80000000, 32'h80000000, 1'b0, 1'b0};
    vec[15] = '{32'h80000000, 32'h80000000, enc(0, 1, 2, 12, 0, 6'h20), 32'd0, 32'h80000000, 1'b1, 1'b0};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02};

    // Reset state
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset in_ready", 32'(rdy), 32'h0);
    chk("reset res_valid", 32'(rv), 32'h0);
    chk("reset resultado d0", res[0], 32'h0);
    chk("reset resultado d1", res[1], 32'h0);
    chk("reset res_rd", 32'({rrd[0], rrd[1]}), 32'h0);
    chk("reset flags", 32'({ovf_o, err_o}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", 32'(rdy), 32'h3);

    // Table-driven vectors
    for (int v = 0; v < 16; v++) begin
      do_cfg(1, vec[v].r1);
      do_cfg(2, vec[v].r2);
      issue(vec[v].ins, $sformatf("vec%0d", v), 1'b0, 1'b0, 5'd0, 32'd0);
      chk($sformatf("vec%0d tbl res d0", v), res[0], vec[v].e0);
      chk($sformatf("vec%0d tbl res d1", v), res[1], vec[v].e1);
      chk($sformatf("vec%0d tbl ovf", v), 32'(ovf_o), {30'd0, vec[v].eo, vec[v].eo});
      chk($sformatf("vec%0d tbl err", v), 32'(err_o), {30'd0, vec[v].ee, vec[v].ee});
    end

    // Register readbacks: writeback landed, illegal ops left R9 alone
    rb(7, "rb R7");
    chk("R7 holds 2077", res[0], 32'd2077);
    rb(9, "rb R9");
    chk("R9 untouched by err", res[0], 32'd1);

    // Writes to R0 and to addresses beyond NREG are dropped
    do_cfg(1, 32'd5); do_cfg(2, 32'd6);
    issue(enc(0, 1, 2, 0, 0, 6'h20), "add rd0", 1'b0, 1'b0, 5'd0, 32'd0);
    rb(0, "rb R0");
    chk("R0 reads 0", res[0], 32'd0);
    issue(enc(0, 1, 2, 20, 0, 6'h20), "add rd20", 1'b0, 1'b0, 5'd0, 32'd0);
    rb(20, "rb R20");
    chk("R20 nreg32", res[0], 32'd11);
    chk("R20 nreg16", res[1], 32'd0);
    do_cfg(0, 32'd123);
    rb(0, "rb R0 cfg");

    // Preload on the accept edge is visible to READ
    issue(enc(0, 1, 0, 15, 0, 6'h25), "cfg+accept", 1'b1, 1'b0, 5'd1, 32'd77);
    chk("cfg+accept value", res[0], 32'd77);

    // Back-to-back with in_valid held high
    do_cfg(1, 32'd100); do_cfg(2, 32'd23);
    ins_b[0] = enc(0, 1, 2, 10, 0, 6'h20);
    ins_b[1] = enc(0, 10, 10, 11, 0, 6'h20);
    ins_b[2] = enc(0, 11, 1, 12, 0, 6'h22);
    instruccion = ins_b[0]; in_valid = 1'b1;
    idx = 0; last_acc = -1; naccept = 0; nres = 0; pending = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (pending) begin
        pending = 1'b0; idx++;
        if (idx < 3) instruccion = ins_b[idx];
        else in_valid = 1'b0;
      end
      if (rv[0]) begin
        nres++;
        if (qr0.size() > 0) begin
          chk($sformatf("b2b res%0d d0", nres), res[0], qr0.pop_front());
          chk($sformatf("b2b res%0d d1", nres), res[1], qr1.pop_front());
        end
      end
      if (rdy == 2'b11 && in_valid) begin
        if (last_acc >= 0) chk("b2b spacing", 32'(cyc - last_acc), 32'd4);
        last_acc = cyc; naccept++;
        model_exec(ins_b[idx], 0, tr, to, te); qr0.push_back(tr);
        model_exec(ins_b[idx], 1, tr, to, te); qr1.push_back(tr);
        pending = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b accepts", 32'(naccept), 32'd3);
    chk("b2b results", 32'(nres), 32'd3);
    rb(12, "rb R12");
    chk("R12 chain", res[0], 32'd146);

    // Randomized instructions against the model
    for (int it = 0; it < 60; it++) begin
      logic [31:0] d;
      int sel, op;
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 4))
          0: d = 32'h7FFFFFFF;
          1: d = 32'h80000000;
          2: d = 32'hFFFFFFFF;
          default: d = $urandom;
        endcase
        do_cfg(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(1, 7)), d);
      end
      sel = int'($urandom_range(0, 9));
      op  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 63)) : 0;
      issue(enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                (sel < 9) ? fns[sel] : int'($urandom_range(0, 63))),
            $sformatf("rnd%0d", it), 1'b0, 1'b0, 5'd0, 32'd0);
    end

    // Reset during EXEC aborts the instruction and clears the bank
    do_cfg(1, 32'd10); do_cfg(2, 32'd20); do_cfg(13, 32'd5);
    instruccion = enc(0, 1, 2, 13, 0, 6'h20); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst in_ready low", 32'(rdy), 32'h0);
    chk("rst resultado", res[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    nrv = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) chk("rst release in_ready", 32'(rdy), 32'h3);
      if (rv != 2'b00) nrv++;
    end
    chk("rst no res_valid", 32'(nrv), 32'd0);
    rb(13, "rb R13");
    chk("R13 cleared", res[0], 32'd0);

    // Preload while busy is ignored
    issue(enc(0, 1, 0, 0, 0, 6'h25), "busycfg", 1'b0, 1'b1, 5'd14, 32'd99);
    rb(14, "rb R14");
    chk("R14 not written", res[0], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
